serial_add_sub: RTL and testbench

- Multi-cycle, parametrised add/subtract unit for the 8-bit CPU datapath; successor to the single-bit full adder.
- Processes STEP bits per clock, least-significant chunk first, with a registered carry between chunks.
- Produces result, carry, signed-overflow and zero flags.
- Uses a start/busy/done handshake toward the control unit.

---
 rtl/serial_add_sub.sv | 104 ++++++++++
 tb/tb_serial_add_sub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract unit: STEP bits per clock, LSB chunk first, registered
// inter-chunk carry, start/busy/done handshake, result and flags held between completions.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [STEP:0]    w_chunk;
  logic             w_cmsb;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_in;
  logic [WIDTH-1:0] w_sum_next;

  // Chunk adder; carry into the chunk MSB recovered from sum ^ a ^ b at that bit
  assign w_chunk    = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]} + (STEP+1)'(r_carry);
  assign w_cmsb     = w_chunk[STEP-1] ^ r_a[STEP-1] ^ r_b[STEP-1];
  assign w_sum_next = (r_sum >> STEP) | (WIDTH'(w_chunk[STEP-1:0]) << (WIDTH - STEP));
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_b_in     = sub ? ~b : b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= sub ? 1'b1 : cin;
            r_sum   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> STEP;
          r_b     <= r_b >> STEP;
          r_carry <= w_chunk[STEP];
          r_sum   <= w_sum_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            result  <= w_sum_next;
            cout    <= w_chunk[STEP];
            ovf     <= w_cmsb ^ w_chunk[STEP];
            zero    <= (w_sum_next == '0);
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: three configurations (8,1), (16,4), (8,8),
// directed vectors plus model-checked vectors, monitor pops on every done pulse.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  t_start;
  logic        t_sub, t_cin;
  logic [15:0] t_a, t_b;

  logic [7:0]  w_r0, w_r2;
  logic [15:0] w_r1;
  logic w_c0, w_o0, w_z0, w_b0, w_d0;
  logic w_c1, w_o1, w_z1, w_b1, w_d1;
  logic w_c2, w_o2, w_z2, w_b2, w_d2;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          d;
    logic [15:0] res;
    logic        c, o, z;
    int          t0;
  } exp_t;

  exp_t        q[$];
  logic [15:0] prev_res [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_sub #(.WIDTH(8), .STEP(1)) u_d0 (
    .clk(clk), .rst(rst), .start(t_start[0]), .sub(t_sub), .a(t_a[7:0]), .b(t_b[7:0]),
    .cin(t_cin), .result(w_r0), .cout(w_c0), .ovf(w_o0), .zero(w_z0), .busy(w_b0), .done(w_d0));

  serial_add_sub #(.WIDTH(16), .STEP(4)) u_d1 (
    .clk(clk), .rst(rst), .start(t_start[1]), .sub(t_sub), .a(t_a), .b(t_b),
    .cin(t_cin), .result(w_r1), .cout(w_c1), .ovf(w_o1), .zero(w_z1), .busy(w_b1), .done(w_d1));

  serial_add_sub #(.WIDTH(8), .STEP(8)) u_d2 (
    .clk(clk), .rst(rst), .start(t_start[2]), .sub(t_sub), .a(t_a[7:0]), .b(t_b[7:0]),
    .cin(t_cin), .result(w_r2), .cout(w_c2), .ovf(w_o2), .zero(w_z2), .busy(w_b2), .done(w_d2));

  function automatic int n_of(input int d);
    case (d)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int width_of(input int d);
    return (d == 1) ? 16 : 8;
  endfunction

  function automatic logic [15:0] res_of(input int d);
    case (d)
      0:       return 16'(w_r0);
      1:       return w_r1;
      default: return 16'(w_r2);
    endcase
  endfunction

  // {busy, done, cout, ovf, zero}
  function automatic logic [4:0] flg_of(input int d);
    case (d)
      0:       return {w_b0, w_d0, w_c0, w_o0, w_z0};
      1:       return {w_b1, w_d1, w_c1, w_o1, w_z1};
      default: return {w_b2, w_d2, w_c2, w_o2, w_z2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   lat;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_done dut%0d: got done with no pending op, want none (cycle %0d)", d, cyc);
    end else begin
      e   = q.pop_front();
      lat = cyc - e.t0;
      if (e.d != d || res_of(d) !== e.res || flg_of(d)[2:0] !== {e.c, e.o, e.z}
          || lat != n_of(d)) begin
        n_err++;
        $display("FAIL done_dut%0d: got res=%h c/o/z=%b lat=%0d want dut%0d res=%h c/o/z=%b%b%b lat=%0d",
                 d, res_of(d), flg_of(d)[2:0], lat, e.d, e.res, e.c, e.o, e.z, n_of(d));
      end
    end
  endtask

  always @(negedge clk) begin
    if (w_d0 === 1'b1) mon(0);
    if (w_d1 === 1'b1) mon(1);
    if (w_d2 === 1'b1) mon(2);
  end

  // One full operation with handshake and hold checks; inputs are scrambled after start
  task automatic op(input int d, input logic [15:0] a, input logic [15:0] b, input logic sub,
                    input logic cin, input logic [15:0] er, input logic ec, input logic eo,
                    input logic ez);
    @(negedge clk);
    t_a = a; t_b = b; t_sub = sub; t_cin = cin; t_start[d] = 1'b1;
    q.push_back('{d, er, ec, eo, ez, cyc + 1});
    @(posedge clk); #1;
    t_start[d] = 1'b0; t_a = ~a; t_b = ~b; t_sub = ~sub; t_cin = ~cin;
    for (int i = 0; i < n_of(d); i++) begin
      chk("busy_run", 16'(flg_of(d)[4:3]), 16'(2'b10));
      chk("result_hold_run", res_of(d), prev_res[d]);
      @(posedge clk); #1;
    end
    chk("busy_done_at_end", 16'(flg_of(d)[4:3]), 16'(2'b01));
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after", 16'(flg_of(d)[4:3]), 16'(2'b00));
    chk("result_held", res_of(d), er);
    chk("scoreboard_drained", 16'(q.size()), 16'd0);
    q.delete();
    prev_res[d] = er;
  endtask

  task automatic rnd(input int d);
    int          w;
    logic [15:0] mask, a, b, bb, res;
    logic [16:0] s;
    logic        sub, cin, o;
    w    = width_of(d);
    mask = 16'((17'h1 << w) - 17'h1);
    a    = 16'($urandom) & mask;
    b    = 16'($urandom) & mask;
    sub  = 1'($urandom);
    cin  = 1'($urandom);
    bb   = sub ? (~b & mask) : b;
    s    = 17'(a) + 17'(bb) + 17'(sub ? 1'b1 : cin);
    res  = s[15:0] & mask;
    o    = (a[w-1] == bb[w-1]) && (res[w-1] != a[w-1]);
    op(d, a, b, sub, cin, res, s[w], o, res == 16'h0);
  endtask

  initial begin
    rst = 1'b1; t_start = '0; t_sub = 1'b0; t_cin = 1'b0; t_a = '0; t_b = '0;
    for (int d = 0; d < 3; d++) prev_res[d] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_result", res_of(d), 16'h0);
      chk("reset_flags", 16'(flg_of(d)), 16'h0);
    end
    rst = 1'b0;

    // Directed, WIDTH=8 STEP=1
    op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0);
    op(0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1);
    op(0, 16'h05, 16'h07, 1'b1, 1'b0, 16'hFE, 1'b0, 1'b0, 1'b0);
    op(0, 16'h80, 16'h80, 1'b0, 1'b1, 16'h01, 1'b1, 1'b1, 1'b0);
    op(0, 16'h80, 16'h01, 1'b1, 1'b0, 16'h7F, 1'b1, 1'b1, 1'b0);
    op(0, 16'h00, 16'h00, 1'b0, 1'b1, 16'h01, 1'b0, 1'b0, 1'b0);
    // Directed, WIDTH=16 STEP=4
    op(1, 16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0, 1'b0);
    op(1, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    op(1, 16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    // Directed, WIDTH=8 STEP=8 (single chunk)
    op(2, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0);
    op(2, 16'h00, 16'h01, 1'b1, 1'b0, 16'hFF, 1'b0, 1'b0, 1'b0);
    op(2, 16'h10, 16'h10, 1'b1, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1);

    // Back-to-back: start held through RUN and DONE, operands changed during RUN
    @(negedge clk);
    t_a = 16'h10; t_b = 16'h20; t_sub = 1'b0; t_cin = 1'b0; t_start[0] = 1'b1;
    q.push_back('{0, 16'h30, 1'b0, 1'b0, 1'b0, cyc + 1});
    @(posedge clk); #1;
    t_a = 16'h03; t_b = 16'h04;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_first_done", 16'(flg_of(0)[4:3]), 16'(2'b01));
    q.push_back('{0, 16'h07, 1'b0, 1'b0, 1'b0, cyc + 1});
    @(posedge clk); #1;
    t_start[0] = 1'b0;
    chk("b2b_second_busy", 16'(flg_of(0)[4:3]), 16'(2'b10));
    chk("b2b_first_result_held", res_of(0), 16'h30);
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_second_done", 16'(flg_of(0)[4:3]), 16'(2'b01));
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_result", res_of(0), 16'h07);
    chk("b2b_drained", 16'(q.size()), 16'd0);
    q.delete();
    prev_res[0] = 16'h07;

    // Reset during the fourth RUN cycle: no done must follow
    @(negedge clk);
    t_a = 16'h11; t_b = 16'h22; t_sub = 1'b0; t_cin = 1'b0; t_start[0] = 1'b1;
    @(posedge clk); #1;
    t_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", 16'(flg_of(0)[4:3]), 16'(2'b10));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_reset_result", res_of(0), 16'h0);
    chk("midrun_reset_flags", 16'(flg_of(0)), 16'h0);
    for (int d = 0; d < 3; d++) prev_res[d] = '0;
    repeat (12) @(posedge clk);
    #1;
    chk("post_reset_quiet_result", res_of(0), 16'h0);
    op(0, 16'h03, 16'h04, 1'b0, 1'b0, 16'h07, 1'b0, 1'b0, 1'b0);

    // Model-checked vectors on every configuration
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 150; k++) rnd(d);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
